// File: rtl/peak_index_finder.sv
// -----------------------------------------------------------------------------
// peak_index_finder
//
// Upstream feeder for the display output stage. The block takes in a stream of
// NDATA samples per frame and tracks the largest sample and its index. At the
// end of each frame it shows that index on dout and that value on peak_val.
// It then drops ena for a HOLD_LEN-cycle hold window. While ena is low, cntout
// counts 0..HOLD_LEN-1. The display stage latches dout when cntout==4 and ena
// is low.
//
// Parameters
//   NDATA      samples per frame (power of two, >= 8)
//   NDATA_LOG  width of the index and counter ports
//   SWIDTH     sample width in bits
//   HOLD_LEN   hold-window length in cycles (5 <= HOLD_LEN <= NDATA)
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-low reset
//   din        in   SWIDTH     sample value
//   din_valid  in   1          din is valid this cycle
//   dout       out  NDATA_LOG  peak index of the last completed frame
//   peak_val   out  SWIDTH     peak sample value of the last completed frame
//   ena        out  1          1 = acquiring, 0 = hold window
//   cntout     out  NDATA_LOG  sample index while acquiring, hold count while holding
//   frame_done out  1          one-cycle pulse on the first hold cycle
//
// Configuration macro
//   PEAK_SIGNED_EN  When defined, samples are two's complement and the peak
//                   compare is signed. When undefined, the compare is unsigned.
//                   Ports and timing are the same in both builds.
//
// Every output is a flop. No combinational path runs from the inputs to the
// outputs.
// -----------------------------------------------------------------------------
module peak_index_finder #(
    parameter int NDATA     = 128,
    parameter int NDATA_LOG = $clog2(NDATA),
    parameter int SWIDTH    = 12,
    parameter int HOLD_LEN  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SWIDTH-1:0]    din,
    input  logic                 din_valid,
    output logic [NDATA_LOG-1:0] dout,
    output logic [SWIDTH-1:0]    peak_val,
    output logic                 ena,
    output logic [NDATA_LOG-1:0] cntout,
    output logic                 frame_done
);

    typedef enum logic [0:0] {
        ST_ACQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [NDATA_LOG-1:0] CNT_ZERO    = {NDATA_LOG{1'b0}};
    localparam logic [NDATA_LOG-1:0] CNT_ONE     = {{(NDATA_LOG-1){1'b0}}, 1'b1};
    localparam logic [NDATA_LOG-1:0] LAST_SAMPLE = NDATA_LOG'(NDATA - 1);
    localparam logic [NDATA_LOG-1:0] LAST_HOLD   = NDATA_LOG'(HOLD_LEN - 1);
    localparam logic [SWIDTH-1:0]    SAMPLE_ZERO = {SWIDTH{1'b0}};

    // Peak compare. It is strict, so a tie keeps the earlier index.
    function automatic logic is_greater(input logic [SWIDTH-1:0] a,
                                        input logic [SWIDTH-1:0] b);
`ifdef PEAK_SIGNED_EN
        return ($signed(a) > $signed(b));
`else
        return (a > b);
`endif
    endfunction

    // Registered state
    state_t                 state_q,      state_d;
    logic [NDATA_LOG-1:0]   cnt_q,        cnt_d;
    logic [SWIDTH-1:0]      max_q,        max_d;
    logic [NDATA_LOG-1:0]   idx_q,        idx_d;
    logic [NDATA_LOG-1:0]   dout_q,       dout_d;
    logic [SWIDTH-1:0]      peak_q,       peak_d;
    logic                   ena_q,        ena_d;
    logic                   frame_done_q, frame_done_d;

    // Running max and index after this cycle's sample is included
    logic [SWIDTH-1:0]      cand_val_s;
    logic [NDATA_LOG-1:0]   cand_idx_s;

    // Running max/index candidate. Sample 0 always loads, so the cleared value
    // of max_q never takes part in a compare. This matters in the signed build.
    always_comb begin
        cand_val_s = max_q;
        cand_idx_s = idx_q;
        if (cnt_q == CNT_ZERO) begin
            cand_val_s = din;
            cand_idx_s = CNT_ZERO;
        end else if (is_greater(din, max_q)) begin
            cand_val_s = din;
            cand_idx_s = cnt_q;
        end else begin
            cand_val_s = max_q;
            cand_idx_s = idx_q;
        end
    end

    // Next-state logic for the acquire/hold sequencer and all output registers
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        idx_d        = idx_q;
        dout_d       = dout_q;
        peak_d       = peak_q;
        ena_d        = ena_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_ACQ: begin
                if (din_valid) begin
                    max_d = cand_val_s;
                    idx_d = cand_idx_s;
                    if (cnt_q == LAST_SAMPLE) begin
                        // The last sample is part of the compare. Publish the
                        // result and start the hold window.
                        state_d      = ST_HOLD;
                        dout_d       = cand_idx_s;
                        peak_d       = cand_val_s;
                        ena_d        = 1'b0;
                        cnt_d        = CNT_ZERO;
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    // Idle cycle: all state is held
                    cnt_d = cnt_q;
                end
            end

            ST_HOLD: begin
                // din_valid is ignored for the whole window, including its
                // last cycle.
                if (cnt_q == LAST_HOLD) begin
                    state_d = ST_ACQ;
                    ena_d   = 1'b1;
                    cnt_d   = CNT_ZERO;
                    max_d   = SAMPLE_ZERO;
                    idx_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                // Illegal encoding: restart acquisition from a clean state
                state_d = ST_ACQ;
                ena_d   = 1'b1;
                cnt_d   = CNT_ZERO;
                max_d   = SAMPLE_ZERO;
                idx_d   = CNT_ZERO;
            end
        endcase
    end

    // Sequencer and output registers. Async reset drops any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_ACQ;
            cnt_q        <= CNT_ZERO;
            max_q        <= SAMPLE_ZERO;
            idx_q        <= CNT_ZERO;
            dout_q       <= CNT_ZERO;
            peak_q       <= SAMPLE_ZERO;
            ena_q        <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            peak_q       <= peak_d;
            ena_q        <= ena_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout       = dout_q;
    assign peak_val   = peak_q;
    assign ena        = ena_q;
    assign cntout     = cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_peak_index_finder.sv
// -----------------------------------------------------------------------------
// tb_peak_index_finder
//
// Directed bench for peak_index_finder, built with NDATA=8 and SWIDTH=12.
//   u_dut   HOLD_LEN=8. Checked against a scoreboard and by direct step checks.
//   u_dut5  HOLD_LEN=5. Used to check the short hold window and the
//           downstream latch on cntout==4.
// For each full frame, the expected peak index and value are computed from
// the stimulus and pushed onto a queue. A monitor pops and compares one entry
// for each frame_done pulse.
// -----------------------------------------------------------------------------
module tb_peak_index_finder;

    localparam int NDATA = 8;
    localparam int NLOG  = 3;
    localparam int SW    = 12;

    typedef logic [SW-1:0] frame_t [NDATA];
    typedef struct packed {
        logic [NLOG-1:0] idx;
        logic [SW-1:0]   val;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [SW-1:0]   din;
    logic            din_valid;

    logic [NLOG-1:0] dout, cntout;
    logic [SW-1:0]   peak_val;
    logic            ena, frame_done;

    logic [NLOG-1:0] dout5, cntout5;
    logic [SW-1:0]   peak_val5;
    logic            ena5, frame_done5;

    logic [NLOG-1:0] latch5_q;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    peak_index_finder #(.NDATA(NDATA), .NDATA_LOG(NLOG), .SWIDTH(SW), .HOLD_LEN(8)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .dout(dout), .peak_val(peak_val), .ena(ena), .cntout(cntout),
        .frame_done(frame_done)
    );

    peak_index_finder #(.NDATA(NDATA), .NDATA_LOG(NLOG), .SWIDTH(SW), .HOLD_LEN(5)) u_dut5 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .dout(dout5), .peak_val(peak_val5), .ena(ena5), .cntout(cntout5),
        .frame_done(frame_done5)
    );

    // Downstream display-stage model: latch dout5 when cntout5==4 during hold
    always @(posedge clk or negedge rst) begin
        if (!rst)                                  latch5_q <= 3'd7;
        else if (ena5 == 1'b0 && cntout5 == 3'd4)  latch5_q <= dout5;
    end

    function automatic bit gt(input logic [SW-1:0] a, input logic [SW-1:0] b);
`ifdef PEAK_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Reference model: first occurrence of the maximum
    function automatic exp_t model(input frame_t s);
        exp_t r;
        r.idx = '0;
        r.val = s[0];
        for (int i = 1; i < NDATA; i++) begin
            if (gt(s[i], r.val)) begin
                r.val = s[i];
                r.idx = i[NLOG-1:0];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: one expected entry per frame_done pulse
    always @(negedge clk) begin
        if (rst === 1'b1 && frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_frame", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_dout", 32'(dout), 32'(e.idx));
                chk("sb_peak_val", 32'(peak_val), 32'(e.val));
            end
        end
    end

    // One clock: drive the inputs, then observe 1 ns after the rising edge
    task automatic cyc(input logic v, input logic [SW-1:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input frame_t s, input bit gapped);
        exp_q.push_back(model(s));
        for (int i = 0; i < NDATA; i++) begin
            cyc(1'b1, s[i]);
            if (i < NDATA - 1) begin
                chk("acq_cntout", 32'(cntout), 32'(i + 1));
                chk("acq_ena", 32'(ena), 32'd1);
                if (gapped) begin
                    cyc(1'b0, 12'hABC);
                    chk("gap_cntout", 32'(cntout), 32'(i + 1));
                end
            end else begin
                chk("end_ena", 32'(ena), 32'd0);
                chk("end_frame_done", 32'(frame_done), 32'd1);
                chk("end_cntout", 32'(cntout), 32'd0);
            end
        end
    endtask

    task automatic wait_acq();
        int n;
        n = 0;
        while (ena !== 1'b1 && n < 20) begin
            cyc(1'b0, 12'h000);
            n++;
        end
        chk("wait_acq", 32'(ena), 32'd1);
    endtask

    initial begin
        frame_t f;

        // Reset state
        rst = 1'b0; din = 12'h000; din_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_peak_val", 32'(peak_val), 32'd0);
        chk("rst_ena", 32'(ena), 32'd1);
        chk("rst_cntout", 32'(cntout), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b1;

        // Test 1: basic frame with a tie on the max value
        f = '{12'd10, 12'd3, 12'd7, 12'd200, 12'd5, 12'd200, 12'd1, 12'd9};
        drive_frame(f, 1'b0);

        // Test 2: hold window. Large samples offered here must be dropped.
        for (int j = 1; j < 8; j++) begin
            cyc(1'b1, 12'hFA0);
            chk("hold_cntout", 32'(cntout), 32'(j));
            chk("hold_ena", 32'(ena), 32'd0);
            chk("hold_frame_done", 32'(frame_done), 32'd0);
        end
        cyc(1'b1, 12'hFA0);
        chk("hold_exit_ena", 32'(ena), 32'd1);
        chk("hold_exit_cntout", 32'(cntout), 32'd0);
        f = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
        drive_frame(f, 1'b0);

        // Test 3: same data as test 1 with gapped valid (15 cycles)
        wait_acq();
        f = '{12'd10, 12'd3, 12'd7, 12'd200, 12'd5, 12'd200, 12'd1, 12'd9};
        drive_frame(f, 1'b1);

        // Test 4: reset in mid-frame, then a frame whose peak is the last sample
        wait_acq();
        cyc(1'b1, 12'd1); cyc(1'b1, 12'd2); cyc(1'b1, 12'd99);
        cyc(1'b1, 12'd3); cyc(1'b1, 12'd4);
        chk("mid_cntout", 32'(cntout), 32'd5);
        rst = 1'b0;
        #1;
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_peak_val", 32'(peak_val), 32'd0);
        chk("arst_ena", 32'(ena), 32'd1);
        chk("arst_cntout", 32'(cntout), 32'd0);
        chk("arst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        f = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd50};
        drive_frame(f, 1'b0);

        // Test 5: negative samples; the model applies the build's compare
        wait_acq();
        f = '{12'hFFB, 12'hFFF, 12'hED4, 12'hFFE, 12'hFF7, 12'hFF9, 12'hFFC, 12'hFF8};
        drive_frame(f, 1'b0);

        // Test 6: HOLD_LEN=5 window and the downstream latch
        wait_acq();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        f = '{12'd5, 12'd9, 12'd2, 12'd9, 12'd1, 12'd0, 12'd3, 12'd8};
        drive_frame(f, 1'b0);
        chk("h5_ena", 32'(ena5), 32'd0);
        chk("h5_frame_done", 32'(frame_done5), 32'd1);
        chk("h5_cntout", 32'(cntout5), 32'd0);
        for (int j = 1; j < 5; j++) begin
            cyc(1'b1, 12'hFA0);
            chk("h5_hold_cntout", 32'(cntout5), 32'(j));
            chk("h5_hold_ena", 32'(ena5), 32'd0);
        end
        cyc(1'b0, 12'h000);
        chk("h5_exit_ena", 32'(ena5), 32'd1);
        chk("h5_exit_cntout", 32'(cntout5), 32'd0);
        chk("h5_latch", 32'(latch5_q), 32'd1);
        chk("h5_peak_val", 32'(peak_val5), 32'd9);

        // Every frame pushed to the scoreboard must have been consumed
        cyc(1'b0, 12'h000);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
